// File: rtl/csr_trap_ctrl.sv
// Commit-stage trap sequencer: picks the highest-priority trap/MRET event at
// commit, hands one atomic command to the CSR file, redirects the front end
// once, then holds commit off until the pipeline has drained.
module csr_trap_ctrl #(
   parameter int unsigned      XLEN     = 64,
   parameter logic [XLEN-1:0]  RESET_PC = XLEN'(64'h8000_0000)
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            commit_valid,
   output logic            commit_ready,
   input  logic [XLEN-1:0] commit_pc,
   input  logic            commit_ecall,
   input  logic            commit_misalign,
   input  logic [XLEN-1:0] commit_badaddr,
   input  logic            commit_mret,
   input  logic [1:0]      priv_mode,
   input  logic            mstatus_mie,
   input  logic [XLEN-1:0] mip,
   input  logic [XLEN-1:0] mie,
   input  logic [XLEN-1:0] mtvec,
   input  logic [XLEN-1:0] mepc,
   output logic            csr_cmd_valid,
   input  logic            csr_cmd_ready,
   output logic            csr_cmd_mret,
   output logic [XLEN-1:0] csr_cause,
   output logic [XLEN-1:0] csr_epc,
   output logic [XLEN-1:0] csr_tval,
   output logic            flush,
   input  logic            pipe_empty,
   output logic            redirect_valid,
   output logic [XLEN-1:0] redirect_pc
);

   typedef enum logic [1:0] {IDLE, ISSUE, REDIRECT, DRAIN} state_e;

   localparam logic [XLEN-1:0] IRQ_MASK = XLEN'(12'h888);

   state_e          state_q, state_d;
   logic            mret_q, mret_d;
   logic [XLEN-1:0] cause_q, cause_d;
   logic [XLEN-1:0] epc_q, epc_d;
   logic [XLEN-1:0] tval_q, tval_d;
   logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;

   logic [XLEN-1:0] pend;
   logic            int_en;
   logic            evt_valid;
   logic            evt_mret;
   logic [XLEN-1:0] evt_cause;
   logic [XLEN-1:0] evt_epc;
   logic [XLEN-1:0] evt_tval;
   logic [XLEN-1:0] base;
   logic [XLEN-1:0] target;
   logic            unused_irq;

   // Only MEI/MSI/MTI are arbitrated; other pending bits are ignored.
   assign unused_irq = |(mip & mie & ~IRQ_MASK);

   // Event arbitration at commit: interrupts (MEI > MSI > MTI), misalign, ecall, mret.
   always_comb begin
      pend      = mip & mie;
      int_en    = (priv_mode != 2'd3) || mstatus_mie;
      evt_valid = 1'b0;
      evt_mret  = 1'b0;
      evt_cause = '0;
      evt_epc   = '0;
      evt_tval  = '0;
      if (commit_valid) begin
         if (int_en && (pend[11] || pend[3] || pend[7])) begin
            evt_valid = 1'b1;
            evt_epc   = commit_pc;
            if (pend[11])     evt_cause = {1'b1, {(XLEN-5){1'b0}}, 4'd11};
            else if (pend[3]) evt_cause = {1'b1, {(XLEN-5){1'b0}}, 4'd3};
            else              evt_cause = {1'b1, {(XLEN-5){1'b0}}, 4'd7};
         end else if (commit_misalign) begin
            evt_valid = 1'b1;
            evt_epc   = commit_pc;
            evt_tval  = commit_badaddr;
         end else if (commit_ecall) begin
            evt_valid = 1'b1;
            evt_epc   = commit_pc;
            evt_cause = XLEN'(8) + XLEN'(priv_mode);
         end else if (commit_mret) begin
            evt_valid = 1'b1;
            evt_mret  = 1'b1;
         end
      end
   end

   // Redirect target from the post-update CSR values; vectored only for interrupts.
   always_comb begin
      base = {mtvec[XLEN-1:2], 2'b00};
      if (mret_q)
         target = mepc;
      else if (mtvec[1:0] == 2'b01 && cause_q[XLEN-1])
         target = base + {{(XLEN-6){1'b0}}, cause_q[3:0], 2'b00};
      else
         target = base;
   end

   // Sequencer next-state and handshake/flush/redirect outputs.
   always_comb begin
      state_d        = state_q;
      mret_d         = mret_q;
      cause_d        = cause_q;
      epc_d          = epc_q;
      tval_d         = tval_q;
      redirect_pc_d  = redirect_pc_q;
      commit_ready   = 1'b0;
      csr_cmd_valid  = 1'b0;
      redirect_valid = 1'b0;
      flush          = 1'b0;
      redirect_pc    = redirect_pc_q;
      case (state_q)
         IDLE: begin
            commit_ready = 1'b1;
            // reset gating keeps flush low while the async reset is asserted
            if (evt_valid && reset) begin
               flush   = 1'b1;
               mret_d  = evt_mret;
               cause_d = evt_cause;
               epc_d   = evt_epc;
               tval_d  = evt_tval;
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            csr_cmd_valid = 1'b1;
            flush         = 1'b1;
            if (csr_cmd_ready) state_d = REDIRECT;
         end
         REDIRECT: begin
            redirect_valid = 1'b1;
            flush          = 1'b1;
            redirect_pc    = target;
            redirect_pc_d  = target;
            state_d        = DRAIN;
         end
         DRAIN: begin
            flush = 1'b1;
            if (pipe_empty) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State and command-field registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= IDLE;
         mret_q        <= 1'b0;
         cause_q       <= '0;
         epc_q         <= '0;
         tval_q        <= '0;
         redirect_pc_q <= RESET_PC;
      end else begin
         state_q       <= state_d;
         mret_q        <= mret_d;
         cause_q       <= cause_d;
         epc_q         <= epc_d;
         tval_q        <= tval_d;
         redirect_pc_q <= redirect_pc_d;
      end
   end

   assign csr_cmd_mret = mret_q;
   assign csr_cause    = cause_q;
   assign csr_epc      = epc_q;
   assign csr_tval     = tval_q;

endmodule

// File: tb/tb_csr_trap_ctrl.sv
// Bench for csr_trap_ctrl: directed literal cases followed by randomized
// traffic compared every cycle against a transaction-level model.
module tb_csr_trap_ctrl;

   localparam logic [63:0] RST_PC = 64'h8000_0000;

   logic        clk = 1'b0;
   logic        reset;
   logic        commit_valid, commit_ready;
   logic [63:0] commit_pc, commit_badaddr;
   logic        commit_ecall, commit_misalign, commit_mret;
   logic [1:0]  priv_mode;
   logic        mstatus_mie;
   logic [63:0] mip, mie, mtvec, mepc;
   logic        csr_cmd_valid, csr_cmd_ready, csr_cmd_mret;
   logic [63:0] csr_cause, csr_epc, csr_tval;
   logic        flush, pipe_empty, redirect_valid;
   logic [63:0] redirect_pc;

   int checks = 0;
   int errors = 0;

   csr_trap_ctrl #(.XLEN(64), .RESET_PC(RST_PC)) dut (
      .clk(clk), .reset(reset),
      .commit_valid(commit_valid), .commit_ready(commit_ready),
      .commit_pc(commit_pc), .commit_ecall(commit_ecall),
      .commit_misalign(commit_misalign), .commit_badaddr(commit_badaddr),
      .commit_mret(commit_mret), .priv_mode(priv_mode), .mstatus_mie(mstatus_mie),
      .mip(mip), .mie(mie), .mtvec(mtvec), .mepc(mepc),
      .csr_cmd_valid(csr_cmd_valid), .csr_cmd_ready(csr_cmd_ready),
      .csr_cmd_mret(csr_cmd_mret), .csr_cause(csr_cause), .csr_epc(csr_epc),
      .csr_tval(csr_tval), .flush(flush), .pipe_empty(pipe_empty),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic idle_inputs();
      commit_valid = 0; commit_ecall = 0; commit_misalign = 0; commit_mret = 0;
      commit_pc = 0; commit_badaddr = 0; priv_mode = 2'd3; mstatus_mie = 0;
      mip = 0; mie = 0; mtvec = 0; mepc = 0; csr_cmd_ready = 0; pipe_empty = 0;
   endtask

   // Lets a sequence complete and waits (bounded) for commit_ready.
   task automatic finish_seq(input string name);
      bit done = 0;
      commit_valid = 0; csr_cmd_ready = 1; pipe_empty = 1;
      for (int i = 0; i < 20 && !done; i++) begin
         @(negedge clk); #1;
         if (commit_ready) done = 1;
      end
      chk({name, "_return_idle"}, 64'(done), 64'd1);
   endtask

   // ---------------- transaction-level reference model ----------------
   typedef struct {
      bit          v;
      bit          mret;
      bit          intr;
      int          code;
      logic [63:0] cause, epc, tval;
   } evt_t;

   function automatic evt_t classify();
      evt_t r;
      int prio[3] = '{11, 3, 7};
      logic [63:0] pend = mip & mie;
      r.v = 0; r.mret = 0; r.intr = 0; r.code = 0; r.cause = 0; r.epc = 0; r.tval = 0;
      if (!commit_valid) return r;
      if (priv_mode != 3 || mstatus_mie) begin
         for (int i = 0; i < 3; i++)
            if (!r.v && pend[prio[i]]) begin
               r.v = 1; r.intr = 1; r.code = prio[i];
               r.cause = (64'd1 << 63) | 64'(prio[i]);
               r.epc = commit_pc;
            end
      end
      if (!r.v && commit_misalign) begin
         r.v = 1; r.epc = commit_pc; r.tval = commit_badaddr;
      end else if (!r.v && commit_ecall) begin
         r.v = 1; r.epc = commit_pc; r.cause = (priv_mode == 0) ? 64'd8 : 64'd11;
      end else if (!r.v && commit_mret) begin
         r.v = 1; r.mret = 1;
      end
      return r;
   endfunction

   // phase: 0 waiting at commit, 1 command offered, 2 redirect, 3 draining
   int          m_phase;
   evt_t        m_cmd;
   logic [63:0] m_rpc;

   function automatic logic [63:0] model_target();
      logic [63:0] base = mtvec & ~64'd3;
      if (m_cmd.mret) return mepc;
      if (mtvec[1:0] == 2'd1 && m_cmd.intr) return base + 64'(4 * m_cmd.code);
      return base;
   endfunction

   task automatic model_reset();
      m_phase = 0; m_rpc = RST_PC;
      m_cmd.v = 0; m_cmd.mret = 0; m_cmd.intr = 0; m_cmd.code = 0;
      m_cmd.cause = 0; m_cmd.epc = 0; m_cmd.tval = 0;
   endtask

   task automatic model_compare();
      evt_t e = classify();
      bit take = (m_phase == 0) && reset && e.v;
      chk("r_commit_ready", 64'(commit_ready), 64'(m_phase == 0));
      chk("r_cmd_valid", 64'(csr_cmd_valid), 64'(m_phase == 1));
      chk("r_redirect_valid", 64'(redirect_valid), 64'(m_phase == 2));
      chk("r_flush", 64'(flush), 64'(m_phase != 0 || take));
      chk("r_cmd_mret", 64'(csr_cmd_mret), 64'(m_cmd.mret));
      chk("r_cause", csr_cause, m_cmd.cause);
      chk("r_epc", csr_epc, m_cmd.epc);
      chk("r_tval", csr_tval, m_cmd.tval);
      chk("r_redirect_pc", redirect_pc, (m_phase == 2) ? model_target() : m_rpc);
   endtask

   task automatic model_step();
      evt_t e = classify();
      case (m_phase)
         0: if (e.v) begin m_cmd = e; m_phase = 1; end
         1: if (csr_cmd_ready) m_phase = 2;
         2: begin m_rpc = model_target(); m_phase = 3; end
         default: if (pipe_empty) m_phase = 0;
      endcase
   endtask

   task automatic randomize_inputs();
      commit_valid    = ($urandom_range(0, 9) < 7);
      commit_ecall    = ($urandom_range(0, 4) == 0);
      commit_misalign = ($urandom_range(0, 6) == 0);
      commit_mret     = ($urandom_range(0, 6) == 0);
      commit_pc       = {$urandom, $urandom};
      commit_badaddr  = {$urandom, $urandom};
      priv_mode       = $urandom_range(0, 1) ? 2'd3 : 2'd0;
      mstatus_mie     = 1'($urandom);
      mie             = 64'($urandom_range(0, 4095));
      mip             = ($urandom_range(0, 9) < 3) ? 64'($urandom_range(0, 4095)) : 64'd0;
      mtvec           = ($urandom_range(0, 9) == 0) ? 64'hFFFF_FFFF_FFFF_FFF1
                                                    : {$urandom, $urandom};
      mepc            = {$urandom, $urandom};
      csr_cmd_ready   = 1'($urandom);
      pipe_empty      = ($urandom_range(0, 9) < 4);
   endtask

   initial begin
      reset = 0;
      idle_inputs();
      repeat (2) @(negedge clk);
      #1;
      chk("rst_commit_ready", 64'(commit_ready), 64'd1);
      chk("rst_cmd_valid", 64'(csr_cmd_valid), 64'd0);
      chk("rst_flush", 64'(flush), 64'd0);
      chk("rst_redirect_pc", redirect_pc, RST_PC);
      chk("rst_cause", csr_cause, 64'd0);
      @(negedge clk); reset = 1;

      // ECALL from U mode
      @(negedge clk);
      commit_valid = 1; commit_ecall = 1; priv_mode = 0; commit_pc = 64'h8000_0010;
      mtvec = 64'h8000_1000; csr_cmd_ready = 1; pipe_empty = 0;
      #1 chk("ecall_accept_flush", 64'(flush), 64'd1);
      @(negedge clk); commit_valid = 0; #1;
      chk("ecall_cmd_valid", 64'(csr_cmd_valid), 64'd1);
      chk("ecall_cause", csr_cause, 64'd8);
      chk("ecall_epc", csr_epc, 64'h8000_0010);
      chk("ecall_tval", csr_tval, 64'd0);
      chk("ecall_ready_low", 64'(commit_ready), 64'd0);
      @(negedge clk); #1;
      chk("ecall_redirect_valid", 64'(redirect_valid), 64'd1);
      chk("ecall_redirect_pc", redirect_pc, 64'h8000_1000);
      @(negedge clk); #1;
      chk("ecall_redirect_once", 64'(redirect_valid), 64'd0);
      chk("ecall_drain_flush", 64'(flush), 64'd1);
      chk("ecall_drain_not_ready", 64'(commit_ready), 64'd0);
      @(negedge clk); pipe_empty = 1; #1;
      chk("ecall_drain_hold", 64'(commit_ready), 64'd0);
      @(negedge clk); #1;
      chk("ecall_back_idle", 64'(commit_ready), 64'd1);
      chk("ecall_flush_off", 64'(flush), 64'd0);
      chk("ecall_pc_held", redirect_pc, 64'h8000_1000);

      // Interrupt priority over ecall, vectored mtvec
      idle_inputs(); reset = 1;
      @(negedge clk);
      commit_valid = 1; commit_ecall = 1; priv_mode = 3; mstatus_mie = 1;
      mip = 64'h888; mie = 64'h888; commit_pc = 64'h8000_0020;
      mtvec = 64'h8000_1001; csr_cmd_ready = 1; pipe_empty = 1;
      @(negedge clk); commit_valid = 0; #1;
      chk("irq_cause", csr_cause, 64'h8000_0000_0000_000B);
      chk("irq_epc", csr_epc, 64'h8000_0020);
      @(negedge clk); #1;
      chk("irq_redirect_pc", redirect_pc, 64'h8000_102C);
      finish_seq("irq");

      // Masked interrupt in M mode: plain commit
      @(negedge clk);
      commit_valid = 1; commit_ecall = 0; priv_mode = 3; mstatus_mie = 0;
      mip = 64'h888; mie = 64'h888; pipe_empty = 0;
      #1;
      chk("masked_ready", 64'(commit_ready), 64'd1);
      chk("masked_flush", 64'(flush), 64'd0);
      @(negedge clk); #1;
      chk("masked_still_idle", 64'(commit_ready), 64'd1);
      chk("masked_no_cmd", 64'(csr_cmd_valid), 64'd0);

      // Back-pressure
      idle_inputs();
      @(negedge clk);
      commit_valid = 1; commit_ecall = 1; priv_mode = 3; commit_pc = 64'h8000_0040;
      mtvec = 64'h8000_1000;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk); commit_valid = 0; #1;
         chk("bp_valid", 64'(csr_cmd_valid), 64'd1);
         chk("bp_cause", csr_cause, 64'd11);
         chk("bp_epc", csr_epc, 64'h8000_0040);
         chk("bp_no_redirect", 64'(redirect_valid), 64'd0);
         chk("bp_ready_low", 64'(commit_ready), 64'd0);
      end
      csr_cmd_ready = 1;
      @(negedge clk); #1;
      chk("bp_redirect", 64'(redirect_valid), 64'd1);
      finish_seq("bp");

      // MRET
      idle_inputs();
      @(negedge clk);
      commit_valid = 1; commit_mret = 1; mepc = 64'h8000_0200; csr_cmd_ready = 1;
      mtvec = 64'h8000_1000;
      @(negedge clk); commit_valid = 0; #1;
      chk("mret_flag", 64'(csr_cmd_mret), 64'd1);
      chk("mret_cause", csr_cause, 64'd0);
      chk("mret_epc", csr_epc, 64'd0);
      @(negedge clk); #1;
      chk("mret_redirect_pc", redirect_pc, 64'h8000_0200);
      finish_seq("mret");

      // Misalign
      idle_inputs();
      @(negedge clk);
      commit_valid = 1; commit_misalign = 1; commit_badaddr = 64'h8000_0102;
      commit_pc = 64'h8000_0100;
      @(negedge clk); commit_valid = 0; #1;
      chk("mis_mret_flag", 64'(csr_cmd_mret), 64'd0);
      chk("mis_cause", csr_cause, 64'd0);
      chk("mis_tval", csr_tval, 64'h8000_0102);
      finish_seq("mis");

      // Reset mid-ISSUE
      idle_inputs();
      @(negedge clk);
      commit_valid = 1; commit_ecall = 1; priv_mode = 0; commit_pc = 64'h8000_0300;
      @(negedge clk); commit_valid = 0; #1;
      chk("midrst_pre_valid", 64'(csr_cmd_valid), 64'd1);
      #1 reset = 0; #1;
      chk("midrst_cmd_valid", 64'(csr_cmd_valid), 64'd0);
      chk("midrst_ready", 64'(commit_ready), 64'd1);
      chk("midrst_redirect_pc", redirect_pc, RST_PC);
      chk("midrst_cause", csr_cause, 64'd0);
      @(negedge clk); reset = 1;

      // Randomized traffic against the model
      model_reset();
      for (int cyc = 0; cyc < 4000; cyc++) begin
         @(negedge clk);
         randomize_inputs();
         reset = ($urandom_range(0, 299) != 0);
         #1;
         if (!reset) model_reset();
         model_compare();
         @(posedge clk);
         if (reset) model_step();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/csr_trap_ctrl.md
Name: csr_trap_ctrl

Overview:
- Commit-stage trap sequencer between the pipeline commit point and the CSR register file.
- Arbitrates synchronous exceptions (instruction-address-misaligned, ECALL), MRET and pending machine interrupts.
- Issues one atomic TRAP/MRET command to the CSR file over a valid/ready handshake, then flushes and redirects the front end.
- Holds commit off until the pipeline has drained.

Parameters:
- XLEN, 64, width of PC, cause, tval and CSR data.
- RESET_PC, 64'h8000_0000, redirect_pc value held while idle and after reset.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset; all state is cleared while reset==0.
- commit_valid  in  1  instruction present at commit.
- commit_ready  out  1  commit accepted this cycle.
- commit_pc  in  XLEN  PC of the committing instruction.
- commit_ecall  in  1  committing instruction is ECALL.
- commit_misalign  in  1  instruction-address-misaligned fault on the committing instruction.
- commit_badaddr  in  XLEN  faulting target address.
- commit_mret  in  1  committing instruction is MRET.
- priv_mode  in  2  current privilege level (0=U, 3=M).
- mstatus_mie  in  1  mstatus.MIE.
- mip  in  XLEN  pending interrupts.
- mie  in  XLEN  enabled interrupts.
- mtvec  in  XLEN  trap vector.
- mepc  in  XLEN  return address.
- csr_cmd_valid  out  1  CSR command valid.
- csr_cmd_ready  in  1  CSR file accepts the command.
- csr_cmd_mret  out  1  1=MRET, 0=TRAP.
- csr_cause  out  XLEN  mcause value.
- csr_epc  out  XLEN  mepc value.
- csr_tval  out  XLEN  mtval value.
- flush  out  1  kill all younger pipeline state.
- pipe_empty  in  1  pipeline reports drained.
- redirect_valid  out  1  one-cycle front-end redirect.
- redirect_pc  out  XLEN  redirect target.

Behaviour:
- Reset (reset==0): state=IDLE, commit_ready=1, csr_cmd_valid=0, flush=0, redirect_valid=0, csr_cmd_mret=0, csr_cause/csr_epc/csr_tval=0, redirect_pc=RESET_PC.
- Reset asserted mid-sequence aborts the sequence immediately with no partial command. After reset the block is in IDLE.
- States: IDLE, ISSUE, REDIRECT, DRAIN.
- commit_ready=1 only in IDLE.
- Pending interrupt: pend = mip & mie, taken only if (priv_mode!=3 or mstatus_mie) and commit_valid.
- Priority in a single cycle, highest first: interrupt MEI(11) > MSI(3) > MTI(7); then misalign; then ecall; then mret.
- Interrupt cause = {1'b1, zeros, code}. Interrupt epc = commit_pc; the instruction is not committed.
- Misalign: cause=0, tval=commit_badaddr.
- ECALL: cause=8 if priv_mode==0, 11 if priv_mode==3; tval=0.
- MRET: csr_cmd_mret=1, cause/epc/tval=0.
- IDLE: commit_valid with any qualifying event latches the command fields, sets flush=1 combinationally that cycle, then goes to ISSUE. Ordinary instructions commit without a transition.
- ISSUE: csr_cmd_valid=1 with fields held stable until handshake. When csr_cmd_ready is high, go to REDIRECT.
- REDIRECT: exactly one cycle with redirect_valid=1, then go to DRAIN.
  - redirect_pc = mepc for MRET.
  - Otherwise base = {mtvec[XLEN-1:2],2'b00}. If mtvec[1:0]==1 and the event is an interrupt, redirect_pc = base + 4*code (modulo 2^XLEN); else redirect_pc = base.
  - mtvec and mepc are sampled in the REDIRECT cycle, i.e. after the CSR update.
- DRAIN: flush=1 until pipe_empty=1, then go to IDLE. flush stays high from the accept cycle through the last DRAIN cycle.
- If pipe_empty is already 1 on DRAIN entry, DRAIN lasts one cycle.
- Minimum sequence is 4 cycles: accept, ISSUE with immediate ready, REDIRECT, DRAIN.
- No new event is accepted before returning to IDLE. The pipeline holds its commit stage while commit_ready=0.
- Output fields are registered; they hold their last values in IDLE.

Test Plan:
- Reset behaviour: assert reset=0 mid-ISSUE -> csr_cmd_valid=0, state IDLE, redirect_pc=0x8000_0000 immediately, with no clock edge needed.
- ECALL path: ECALL from U, commit_pc=0x8000_0010, mtvec=0x8000_1000, ready=1 -> cmd cause=8, epc=0x8000_0010. Then redirect_valid for 1 cycle with pc=0x8000_1000. Then commit_ready returns once pipe_empty.
- Interrupt priority and vectoring: in M mode with MIE=1, mip=mie=0x888 and a commit carrying ecall, mtvec=0x8000_1001 -> cause=0x8000_0000_0000_000B, redirect_pc=0x8000_102C, ecall is not reported.
- Masked interrupt: same interrupt with MIE=0 in M mode -> no interrupt taken; a plain instruction commits with commit_ready=1 and no flush.
- Back-pressure: csr_cmd_ready held low for 5 cycles -> csr_cmd_valid and fields stable for 5 cycles, no redirect, commit_ready=0 throughout.
- MRET and misalign: MRET with mepc=0x8000_0200 -> csr_cmd_mret=1, redirect_pc=0x8000_0200. Separately, misalign with badaddr=0x8000_0102 -> cause=0, tval=0x8000_0102.
